// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the unified memory port arbiter
// Purpose: arbiter FSM state encoding and starvation counter width.
// Ports: none (package).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY_IF = 2'b01,
    ARB_BUSY_DM = 2'b10
  } arb_state_e;

  // Wide enough for STARVE_MAX up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating count of DM grants made while IF waits
// Purpose: tracks consecutive DM wins over a pending fetch; at_max forces an IF grant.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   inc       DM granted while a fetch is pending
//   clr       IF granted
//   at_max    count has reached STARVE_MAX
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(STARVE_MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data access
// Purpose: arbitrates IF and DM requests onto one memory port, generates pipeline stalls
//          and drops fetch responses killed by a redirect.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr/if_kill        fetch request, PC, redirect
//   if_rdata/if_ready/if_stall    fetched instruction, done pulse, IF stall
//   dm_req/dm_we/dm_addr          data request, store flag, address
//   dm_wdata/dm_wbits             store data and size
//   dm_rdata/dm_ready/dm_stall    load data, done pulse, pipeline stall
//   mem_req/we/addr/wdata/wbits   memory request bundle, held until mem_ack
//   mem_rdata/mem_ack             memory read data and completion
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_wbits,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_wbits,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_e        state_q, state_d;
  logic              kill_q, kill_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_wbits_q, mem_wbits_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic if_elig, dm_elig, grant_if, grant_dm, starve_at_max;

  // A requester in its ready cycle is still holding req for the finished access.
  assign if_elig = if_req & ~if_ready_q & ~if_kill;
  assign dm_elig = dm_req & ~dm_ready_q;

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (if_elig && starve_at_max) begin
        grant_if = 1'b1;
      end else if (dm_elig) begin
        grant_dm = 1'b1;
      end else if (if_elig) begin
        grant_if = 1'b1;
      end
    end
  end

  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (grant_dm & if_req),
    .clr    (grant_if),
    .at_max (starve_at_max)
  );

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wbits_d = mem_wbits_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_if) begin
          state_d     = ARB_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wbits_d = 2'b00;
        end else if (grant_dm) begin
          state_d     = ARB_BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wbits_d = dm_wbits;
        end
      end
      ARB_BUSY_IF: begin
        if (if_kill) begin
          kill_d = 1'b1;
        end
        if (mem_ack) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          kill_d    = 1'b0;
          // A redirect seen at any point of the access discards its data.
          if (!kill_q && !if_kill) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      ARB_BUSY_DM: begin
        if (mem_ack) begin
          state_d    = ARB_IDLE;
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wbits_q <= 2'b00;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wbits_q <= mem_wbits_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wbits = mem_wbits_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  // A redirect in the ready cycle turns the completed fetch into a bubble.
  assign if_ready  = if_ready_q & ~if_kill;
  assign dm_stall  = dm_req & ~dm_ready_q;
  assign if_stall  = (if_req & ~if_ready) | dm_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        we;
    logic [1:0]  wbits;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_tx_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_kill;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready, if_stall;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [1:0]  dm_wbits;
  logic [31:0] dm_rdata;
  logic        dm_ready, dm_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_wbits;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ws = 1;
  logic        manual = 1'b0;
  logic        late_ack = 1'b0;

  mem_tx_t     exp_mem[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wbits(dm_wbits),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wbits(mem_wbits), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic mem_tx_t tx(input logic we, input logic [1:0] wb, input logic [31:0] a,
                                 input logic [31:0] wd);
    mem_tx_t t;
    t.we = we; t.wbits = wb; t.addr = a; t.wdata = wd;
    return t;
  endfunction

  // Memory model: ack after ws wait cycles, read data = {addr[15:0], 16'hC0DE}.
  task automatic responder();
    int wcnt = 0;
    forever begin
      @(negedge clk);
      if (manual) begin
        mem_ack = late_ack;
      end else if (mem_req && !mem_ack) begin
        if (wcnt == ws) begin
          mem_ack = 1'b1;
          mem_rdata = {mem_addr[15:0], 16'hC0DE};
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    mem_tx_t act, req;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req && mem_ack) begin
        chk("mem_tx_expected", exp_mem.size() != 0, 1'b1);
        if (exp_mem.size() != 0) begin
          req = exp_mem.pop_front();
          act = tx(mem_we, mem_wbits, mem_addr, mem_we ? mem_wdata : 32'h0);
          chk("mem_tx", act, req);
        end
      end
      if (if_ready) begin
        chk("if_resp_expected", exp_if.size() != 0, 1'b1);
        if (exp_if.size() != 0) begin
          d = exp_if.pop_front();
          chk("if_rdata", if_rdata, d);
        end
      end
      if (dm_ready) begin
        chk("dm_resp_expected", exp_dm.size() != 0, 1'b1);
        if (exp_dm.size() != 0) begin
          d = exp_dm.pop_front();
          chk("dm_rdata", dm_rdata, d);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_if_ready(output int at);
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if_ready) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_dm_ready(output int at);
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dm_ready) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t0, at, nd, ni, if_at;
    fork
      responder();
      monitor();
      forever begin
        @(posedge clk);
        cyc++;
      end
      begin
        #50000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
      end
    join_none

    rst = 1'b1; if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wbits = 2'b00;
    repeat (3) step();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_if_ready", if_ready, 1'b0);
    chk("rst_dm_ready", dm_ready, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    step();
    rst = 1'b0;
    step();

    // 1: single fetch, one wait state
    ws = 1;
    exp_mem.push_back(tx(1'b0, 2'b00, 32'h0000_3000, 32'h0));
    exp_if.push_back(32'h3000_C0DE);
    if_req = 1'b1; if_addr = 32'h0000_3000; t0 = cyc;
    @(negedge clk);
    chk("t1_if_stall_wait", if_stall, 1'b1);
    wait_if_ready(at);
    chk("t1_if_latency", at - t0, 3);
    chk("t1_if_stall_ready", if_stall, 1'b0);
    step();
    if_req = 1'b0;
    repeat (2) step();

    // 2: simultaneous IF and DM load, DM first
    exp_mem.push_back(tx(1'b0, 2'b00, 32'h0000_0010, 32'h0));
    exp_mem.push_back(tx(1'b0, 2'b00, 32'h0000_3004, 32'h0));
    exp_dm.push_back(32'h0010_C0DE);
    exp_if.push_back(32'h3004_C0DE);
    if_req = 1'b1; if_addr = 32'h0000_3004;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010; t0 = cyc;
    @(negedge clk);
    chk("t2_dm_stall", dm_stall, 1'b1);
    chk("t2_if_stall", if_stall, 1'b1);
    wait_dm_ready(at);
    chk("t2_dm_latency", at - t0, 3);
    chk("t2_if_stall_held", if_stall, 1'b1);
    step();
    dm_req = 1'b0;
    wait_if_ready(at);
    chk("t2_if_latency", at - t0, 6);
    step();
    if_req = 1'b0;
    repeat (2) step();

    // 3: starvation, IF blocked by redirect until 4 DM grants accumulate
    ws = 0;
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back(tx(1'b0, 2'b00, 32'h0000_0020, 32'h0));
      exp_dm.push_back(32'h0020_C0DE);
    end
    exp_mem.push_back(tx(1'b0, 2'b00, 32'h0000_3100, 32'h0));
    exp_if.push_back(32'h3100_C0DE);
    exp_mem.push_back(tx(1'b0, 2'b00, 32'h0000_0020, 32'h0));
    exp_dm.push_back(32'h0020_C0DE);
    if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h0000_3100;
    dm_req = 1'b1; dm_addr = 32'h0000_0020; t0 = cyc;
    nd = 0; ni = 0; if_at = -1;
    for (int k = 0; k < 60 && !(nd == 5 && ni == 1); k++) begin
      @(negedge clk);
      if (dm_ready) nd++;
      if (if_ready) begin
        ni++;
        if_at = cyc;
      end
      step();
      if (nd == 4) if_kill = 1'b0;
      if (ni == 1) if_req = 1'b0;
      if (nd == 5) dm_req = 1'b0;
    end
    chk("t3_dm_count", nd, 5);
    chk("t3_if_count", ni, 1);
    chk("t3_if_ready_cycle", if_at - t0, 14);
    if_req = 1'b0; dm_req = 1'b0; if_kill = 1'b0;
    repeat (2) step();

    // 4: redirect during a 3-wait-state fetch
    ws = 3;
    exp_mem.push_back(tx(1'b0, 2'b00, 32'h0000_3200, 32'h0));
    exp_mem.push_back(tx(1'b0, 2'b00, 32'h0000_4000, 32'h0));
    exp_if.push_back(32'h4000_C0DE);
    if_req = 1'b1; if_addr = 32'h0000_3200; t0 = cyc;
    step();
    step();
    if_kill = 1'b1; if_addr = 32'h0000_4000;
    step();
    if_kill = 1'b0;
    wait_if_ready(at);
    chk("t4_new_pc_latency", at - t0, 10);
    step();
    if_req = 1'b0;
    repeat (2) step();

    // 5: half-word store leaves load data untouched
    ws = 0;
    exp_mem.push_back(tx(1'b1, 2'b01, 32'h0000_0040, 32'hDEAD_BEEF));
    exp_dm.push_back(32'h0020_C0DE);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0040;
    dm_wdata = 32'hDEAD_BEEF; dm_wbits = 2'b01; t0 = cyc;
    wait_dm_ready(at);
    chk("t5_store_latency", at - t0, 2);
    step();
    dm_req = 1'b0; dm_we = 1'b0; dm_wbits = 2'b00;
    repeat (2) step();

    // 6: reset during a DM access, then a late ack
    manual = 1'b1; late_ack = 1'b0;
    dm_req = 1'b1; dm_addr = 32'h0000_0050;
    step();
    @(negedge clk);
    chk("t6_busy_mem_req", mem_req, 1'b1);
    step();
    rst = 1'b1; dm_req = 1'b0;
    step();
    @(negedge clk);
    chk("t6_rst_mem_req", mem_req, 1'b0);
    chk("t6_rst_mem_addr", mem_addr, 32'h0);
    chk("t6_rst_dm_rdata", dm_rdata, 32'h0);
    step();
    rst = 1'b0; late_ack = 1'b1;
    step();
    late_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_no_dm_ready", dm_ready, 1'b0);
      chk("t6_no_mem_req", mem_req, 1'b0);
    end
    manual = 1'b0;
    repeat (2) step();

    chk("end_mem_queue", exp_mem.size(), 0);
    chk("end_if_queue", exp_if.size(), 0);
    chk("end_dm_queue", exp_dm.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
